code_bucket_counter: RTL and testbench
======================================

// Module: code_bucket_counter
// PURPOSE
//   Input stage ahead of the code-decode logic. Accepts a stream of byte codes over
//   valid/ready and classifies each code by priority into bucket 0-1, 2-3, 4-7 or OTHER.
//   Flags codes outside the unique-decode set {0,1,2,4}.
//   Keeps saturating per-bucket and miss counters, and forwards code+bucket downstream
//   through one registered valid/ready stage.
// PARAMETERS
//   CNT_W   16  width of each statistics counter (saturating)
// PORTS
//   clk             in   1      single clock, rising edge
//   rst             in   1      asynchronous, active-high reset
//   in_valid        in   1      upstream code valid
//   in_ready        out  1      block can accept a code this cycle
//   in_code         in   8      byte code
//   out_valid       out  1      registered code/bucket valid
//   out_ready       in   1      downstream accepts
//   out_code        out  8      registered copy of accepted code
//   out_bucket      out  2      0:{0,1} 1:{2,3} 2:{4..7} 3:OTHER(>=8)
//   out_umiss       out  1      code not in {0,1,2,4}
//   clr             in   1      synchronous clear of counters and sticky flag
//   cnt_sel         in   3      0..3 bucket counter, 4 miss counter, 5..7 read 0
//   cnt_rd          out  CNT_W  combinational readback of selected counter
//   umiss_sticky    out  1      set on any accepted umiss code, cleared by clr/rst
// BEHAVIOUR
//   - Reset (async, immediate):
//     - out_valid=0, out_code=0, out_bucket=0, out_umiss=0.
//     - All counters=0, umiss_sticky=0.
//   - Handshake:
//     - in_ready = !out_valid | out_ready (combinational, no bubble).
//     - Accept when in_valid & in_ready.
//     - Output holds stable while out_valid & !out_ready.
//   - Latency: accepted code appears on out_* the next cycle with out_valid=1.
//     - out_valid drops after an out_valid & out_ready cycle with no new accept.
//   - Classification (priority order, first match wins):
//     1. in_code[7:3]!=0 -> 3 (OTHER)
//     2. in_code[2:1]==0 -> 0
//     3. in_code[2]==0 -> 1
//     4. else -> 2
//   - umiss = in_code not in {0,1,2,4}. Codes 3 and 5-7 land in buckets 1/2 and still
//     set umiss.
//   - Counters:
//     - On accept, the counter for the computed bucket increments by 1.
//     - If umiss, the miss counter also increments.
//     - Both update in the same edge as the output register.
//     - Saturate at 2^CNT_W-1; never wrap.
//   - clr vs accept in the same cycle:
//     - clr wins: all counters go to 0 and the accepted code is NOT counted.
//     - The code is still forwarded to out_*.
//     - umiss_sticky is also cleared.
//   - clr does not affect out_valid/out_code/handshake.
//   - cnt_rd shows the register value (pre-edge). An update is visible the cycle after
//     the accept.
//   - Reset mid-transfer: a pending output is dropped (out_valid=0). Upstream must
//     re-send.
//   - in_code X/Z while in_valid=1 is a protocol error; the bench asserts against it.
// TESTING
//   - Reset: assert rst mid-stream with out_valid=1.
//     - out_valid=0, cnt_rd=0 for all sel, umiss_sticky=0 immediately.
//   - Sweep: codes 0..8, one per cycle, out_ready=1. Required results:
//     - out_bucket = 0,0,1,1,2,2,2,2,3.
//     - out_umiss set for 3,5,6,7,8.
//     - Bucket counts 2,2,4,1; miss count 5.
//   - Backpressure: out_ready=0 for 3 cycles with in_valid=1.
//     - in_ready=0 after the first accept; out_code holds; only 1 count added.
//     - Release: stream resumes with no loss or duplication.
//   - Saturation: CNT_W=4, send 20 codes of value 2.
//     - cnt_rd(sel=1)=15; no wrap.
//   - clr with simultaneous accept of code 5.
//     - Counters=0, sticky=0 next cycle.
//     - out_code=5, out_bucket=2, out_umiss=1.
//   - Random valid/ready throttling vs a reference model: counts and output order match
//     exactly.

Source files
------------

// File: rtl/code_bucket_counter_if.sv
// code_bucket_counter_if: the code stream into the block and the classified stream out of it.
// Latency: none; this is a bundle of wires.
// Backpressure: in_ready/out_ready carry the valid/ready handshake on each side.
// Ports: in_valid/in_ready/in_code (upstream), out_valid/out_ready/out_code/out_bucket/out_umiss (downstream).
// master = the environment (drives codes, consumes results); slave = code_bucket_counter.
interface code_bucket_counter_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_code;
  logic [1:0] out_bucket;
  logic       out_umiss;

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_code, out_bucket, out_umiss
  );

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_code, out_bucket, out_umiss
  );
endinterface

// File: rtl/code_bucket_counter.sv
// code_bucket_counter: classifies byte codes into priority buckets, keeps saturating stats, forwards code+bucket.
// Latency: one cycle from accept to out_valid on the registered output stage.
// Backpressure: in_ready = !out_valid | out_ready; the output holds while out_valid & !out_ready.
// Ports: clk, rst (async, active-high); bus (slave side of code_bucket_counter_if);
//        clr (sync clear of stats), cnt_sel / cnt_rd (counter readback), umiss_sticky.
module code_bucket_counter #(
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  code_bucket_counter_if.slave        bus,
  input  logic                        clr,
  input  logic [2:0]                  cnt_sel,
  output logic [CNT_W-1:0]            cnt_rd,
  output logic                        umiss_sticky
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             out_valid_q,  out_valid_d;
  logic [7:0]       out_code_q,   out_code_d;
  logic [1:0]       out_bucket_q, out_bucket_d;
  logic             out_umiss_q,  out_umiss_d;
  logic [CNT_W-1:0] bkt_cnt_q [4];
  logic [CNT_W-1:0] bkt_cnt_d [4];
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic             umiss_sticky_q, umiss_sticky_d;

  logic             accept;
  logic [1:0]       in_bucket;
  logic             in_umiss;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Priority classification: first matching rule wins.
  always_comb begin
    if (bus.in_code[7:3] != 5'd0) begin
      in_bucket = 2'd3;
    end else if (bus.in_code[2:1] == 2'd0) begin
      in_bucket = 2'd0;
    end else if (!bus.in_code[2]) begin
      in_bucket = 2'd1;
    end else begin
      in_bucket = 2'd2;
    end
    // Only 0,1,2,4 decode uniquely; 3 and 5..7 share a bucket yet still miss.
    in_umiss = !((bus.in_code == 8'd0) || (bus.in_code == 8'd1) ||
                 (bus.in_code == 8'd2) || (bus.in_code == 8'd4));
  end

  // No bubble: a draining output slot can be refilled in the same cycle.
  assign bus.in_ready = !out_valid_q | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    out_valid_d    = out_valid_q;
    out_code_d     = out_code_q;
    out_bucket_d   = out_bucket_q;
    out_umiss_d    = out_umiss_q;
    bkt_cnt_d      = bkt_cnt_q;
    miss_cnt_d     = miss_cnt_q;
    umiss_sticky_d = umiss_sticky_q;

    if (accept) begin
      out_valid_d  = 1'b1;
      out_code_d   = bus.in_code;
      out_bucket_d = in_bucket;
      out_umiss_d  = in_umiss;
    end else if (bus.out_ready) begin
      out_valid_d  = 1'b0;
    end

    // clr takes priority over counting, but never blocks forwarding above.
    if (clr) begin
      for (int i = 0; i < 4; i++) begin
        bkt_cnt_d[i] = '0;
      end
      miss_cnt_d     = '0;
      umiss_sticky_d = 1'b0;
    end else if (accept) begin
      bkt_cnt_d[in_bucket] = sat_inc(bkt_cnt_q[in_bucket]);
      if (in_umiss) begin
        miss_cnt_d     = sat_inc(miss_cnt_q);
        umiss_sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_code_q     <= 8'd0;
      out_bucket_q   <= 2'd0;
      out_umiss_q    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        bkt_cnt_q[i] <= '0;
      end
      miss_cnt_q     <= '0;
      umiss_sticky_q <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_code_q     <= out_code_d;
      out_bucket_q   <= out_bucket_d;
      out_umiss_q    <= out_umiss_d;
      for (int i = 0; i < 4; i++) begin
        bkt_cnt_q[i] <= bkt_cnt_d[i];
      end
      miss_cnt_q     <= miss_cnt_d;
      umiss_sticky_q <= umiss_sticky_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_code   = out_code_q;
  assign bus.out_bucket = out_bucket_q;
  assign bus.out_umiss  = out_umiss_q;
  assign umiss_sticky   = umiss_sticky_q;

  // Readback shows stored values, so an accept becomes visible one cycle later.
  always_comb begin
    case (cnt_sel)
      3'd0, 3'd1, 3'd2, 3'd3: cnt_rd = bkt_cnt_q[cnt_sel[1:0]];
      3'd4:                   cnt_rd = miss_cnt_q;
      default:                cnt_rd = '0;
    endcase
  end
endmodule

// File: tb/tb_code_bucket_counter.sv
// tb_code_bucket_counter: randomized and directed checks of code_bucket_counter against a behavioural model.
// Latency: model expects each accepted code on out_* one cycle later.
// Backpressure: model tracks a single output slot and the no-bubble ready rule.
module tb_code_bucket_counter;
  localparam int MAXV = 65535;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [2:0]  cnt_sel;
  logic [15:0] cnt_rd;
  logic        umiss_sticky;

  logic        sat_clr;
  logic [2:0]  sat_sel;
  logic [3:0]  sat_rd;
  logic        sat_sticky;

  code_bucket_counter_if bus ();
  code_bucket_counter_if sat_bus ();

  code_bucket_counter #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .clr(clr),
    .cnt_sel(cnt_sel), .cnt_rd(cnt_rd), .umiss_sticky(umiss_sticky)
  );

  code_bucket_counter #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .bus(sat_bus.slave), .clr(sat_clr),
    .cnt_sel(sat_sel), .cnt_rd(sat_rd), .umiss_sticky(sat_sticky)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && bus.in_valid) begin
      assert (!$isunknown(bus.in_code)) else $error("in_code unknown while in_valid");
    end
  end

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model: one output slot plus stats held as plain integers.
  bit m_occ;
  int m_code;
  int m_cnt [5];
  bit m_sticky;

  int sweep_bkt [9] = '{0, 0, 1, 1, 2, 2, 2, 2, 3};
  int sweep_um  [9] = '{0, 0, 0, 1, 0, 1, 1, 1, 1};
  int sweep_cnt [5] = '{2, 2, 4, 1, 5};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_bucket(input int c);
    if (c < 2) return 0;
    if (c < 4) return 1;
    if (c < 8) return 2;
    return 3;
  endfunction

  function automatic int exp_umiss(input int c);
    return (c == 0 || c == 1 || c == 2 || c == 4) ? 0 : 1;
  endfunction

  function automatic int m_rd(input int sel);
    return (sel < 5) ? m_cnt[sel] : 0;
  endfunction

  task automatic model_reset();
    m_occ    = 1'b0;
    m_code   = 0;
    m_sticky = 1'b0;
    for (int i = 0; i < 5; i++) m_cnt[i] = 0;
  endtask

  task automatic bump(input int i);
    if (m_cnt[i] < MAXV) m_cnt[i]++;
  endtask

  // Check the pre-edge state at the falling edge, advance the model, land at posedge+1.
  task automatic cycle();
    bit acc;
    @(negedge clk);
    chk("out_valid", 32'(bus.out_valid), 32'(m_occ));
    if (m_occ) begin
      chk("out_code",   32'(bus.out_code),   32'(m_code));
      chk("out_bucket", 32'(bus.out_bucket), 32'(exp_bucket(m_code)));
      chk("out_umiss",  32'(bus.out_umiss),  32'(exp_umiss(m_code)));
    end
    chk("in_ready", 32'(bus.in_ready), 32'(!m_occ || bus.out_ready));
    chk("cnt_rd",   32'(cnt_rd),       32'(m_rd(int'(cnt_sel))));
    chk("sticky",   32'(umiss_sticky), 32'(m_sticky));
    acc = bus.in_valid && (!m_occ || bus.out_ready);
    if (m_occ && bus.out_ready) m_occ = 1'b0;
    if (acc) begin
      m_occ  = 1'b1;
      m_code = int'(bus.in_code);
    end
    if (clr) begin
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
      m_sticky = 1'b0;
    end else if (acc) begin
      bump(exp_bucket(m_code));
      if (exp_umiss(m_code) != 0) begin
        bump(4);
        m_sticky = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic read_cnt(input string tag, input int sel, input int exp);
    cnt_sel = 3'(sel);
    #1;
    chk(tag, 32'(cnt_rd), 32'(exp));
  endtask

  initial begin
    int pre;
    rst = 1'b1;
    clr = 1'b0;
    cnt_sel = 3'd0;
    bus.in_valid = 1'b0;
    bus.in_code = 8'd0;
    bus.out_ready = 1'b0;
    sat_clr = 1'b0;
    sat_sel = 3'd1;
    sat_bus.in_valid = 1'b0;
    sat_bus.in_code = 8'd0;
    sat_bus.out_ready = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_code",  32'(bus.out_code),  32'd0);
    chk("rst_sticky",    32'(umiss_sticky),  32'd0);
    chk("rst_cnt",       32'(cnt_rd),        32'd0);
    rst = 1'b0;

    // Sweep codes 0..8 with the output always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cnt_sel = 3'($urandom_range(0, 7));
      bus.in_valid = 1'b1;
      bus.in_code = 8'(i);
      cycle();
      chk("sweep_bucket", 32'(bus.out_bucket), 32'(sweep_bkt[i]));
      chk("sweep_umiss",  32'(bus.out_umiss),  32'(sweep_um[i]));
    end
    bus.in_valid = 1'b0;
    cycle();
    for (int s = 0; s < 5; s++) read_cnt("sweep_count", s, sweep_cnt[s]);
    read_cnt("sel5_zero", 5, 0);
    read_cnt("sel7_zero", 7, 0);
    chk("sweep_sticky", 32'(umiss_sticky), 32'd1);

    // Backpressure: three stalled cycles with a second code waiting
    cnt_sel = 3'd2;
    pre = m_cnt[2];
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_code = 8'd6;
    cycle();
    bus.in_code = 8'd1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold_code", 32'(bus.out_code), 32'd6);
      chk("bp_in_ready",  32'(bus.in_ready), 32'd0);
    end
    chk("bp_one_count", 32'(cnt_rd), 32'(pre + 1));
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_resume_code", 32'(bus.out_code), 32'd1);
    bus.in_code = 8'd4;
    cycle();
    bus.in_code = 8'd7;
    cycle();
    bus.in_valid = 1'b0;
    cycle();
    cycle();

    // clr together with an accept of code 5
    clr = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_code = 8'd5;
    cycle();
    clr = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_out_code",   32'(bus.out_code),   32'd5);
    chk("clr_out_bucket", 32'(bus.out_bucket), 32'd2);
    chk("clr_out_umiss",  32'(bus.out_umiss),  32'd1);
    chk("clr_sticky",     32'(umiss_sticky),   32'd0);
    for (int s = 0; s < 5; s++) read_cnt("clr_count", s, 0);
    cycle();

    // Reset while an output is pending
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_code = 8'd3;
    cycle();
    bus.in_valid = 1'b0;
    chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_sticky",    32'(umiss_sticky),  32'd0);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    for (int s = 0; s < 5; s++) read_cnt("midrst_count", s, 0);
    rst = 1'b0;
    model_reset();
    cycle();

    // Random valid/ready throttling with occasional clr
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_code   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 9)) : 8'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      clr           = ($urandom_range(0, 39) == 0);
      cnt_sel       = 3'($urandom_range(0, 7));
      cycle();
    end
    clr = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    cycle();

    // Saturation on the 4-bit instance: 20 codes of value 2
    sat_bus.out_ready = 1'b1;
    sat_bus.in_valid = 1'b1;
    sat_bus.in_code = 8'd2;
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    sat_sel = 3'd1;
    chk("sat_count14", 32'(sat_rd), 32'd14);
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    sat_bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("sat_count20", 32'(sat_rd), 32'd15);
    sat_sel = 3'd4;
    #1;
    chk("sat_miss", 32'(sat_rd), 32'd0);
    sat_sel = 3'd0;
    #1;
    chk("sat_bkt0", 32'(sat_rd), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
